// File: rtl/fst_in_port_if.sv
// ============================================================================
// Module      : fst_in_port_if
// Description : Operator-input bundle between the fst core and the input
//               port: raw switch/button lines, read strobe, and FIFO status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fst_in_port_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]        sw_in;
  logic                     btn_n_in;
  logic                     rd_req;
  logic                     clr_ovf;
  logic [DATA_W-1:0]        in_dat;
  logic                     in_valid;
  logic                     fifo_full;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;

  // Core / board side: drives the raw inputs and strobes, observes the FIFO
  modport master (
    output sw_in, btn_n_in, rd_req, clr_ovf,
    input  in_dat, in_valid, fifo_full, fifo_count, overflow
  );

  // Port side: the fst_in_port block itself
  modport slave (
    input  sw_in, btn_n_in, rd_req, clr_ovf,
    output in_dat, in_valid, fifo_full, fifo_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/fst_in_port.sv
// ============================================================================
// Module      : fst_in_port
// Description : Operator input port for the fst core. Synchronizes and
//               debounces a push-button; each accepted press captures the
//               switch bank into a FIFO whose head is presented on in_dat
//               with a valid / read-strobe handshake.
//               Optional feature macro: FST_IN_AUTOREPEAT_EN (auto-repeat
//               while the button is held, period REPEAT_CYC).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fst_in_port #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_CYC   = 500000
) (
  input  wire logic          clk_in,
  input  wire logic          reset_n_in,
  fst_in_port_if.slave       bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [DEB_W-1:0] c_deb_one  = DEB_W'(1);
  localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEBOUNCE_CYC - 1);

  // Reject configurations the pointer arithmetic and debounce counter cannot handle
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEBOUNCE_CYC < 2) ||
      (REPEAT_CYC < 1)) begin : g_param_check
    $error("fst_in_port: illegal DEPTH/DEBOUNCE_CYC/REPEAT_CYC");
  end

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizers
  // --------------------------------------------------------------------------
  logic [1:0]        r_btn_sync;
  logic [DATA_W-1:0] r_sw_meta;
  logic [DATA_W-1:0] r_sw_s;
  logic              w_btn_s;

  assign w_btn_s = r_btn_sync[1];

  // Two-flop synchronizers; the button idles high (released)
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_btn_sync <= 2'b11;
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], bus.btn_n_in};
      r_sw_meta  <= bus.sw_in;
      r_sw_s     <= r_sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM. The debounced level is implied by the state: it is high in
  // RELEASED / PRESS_WAIT and low in PRESSED / RELEASE_WAIT.
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic              r_press_ev;

`ifdef FST_IN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYC + 1);
  localparam logic [RPT_W-1:0] c_rpt_last = RPT_W'(REPEAT_CYC - 1);
  logic [RPT_W-1:0]  r_rpt_cnt;
`endif

  // Debounce state machine; emits a one-cycle press event on accepted presses
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state    <= ST_RELEASED;
      r_deb_cnt  <= '0;
      r_press_ev <= 1'b0;
`ifdef FST_IN_AUTOREPEAT_EN
      r_rpt_cnt  <= '0;
`endif
    end else begin
      r_press_ev <= 1'b0;
      case (r_state)
        ST_RELEASED: begin
          if (!w_btn_s) begin
            r_state   <= ST_PRESS_WAIT;
            r_deb_cnt <= c_deb_one;
          end
        end
        ST_PRESS_WAIT: begin
          if (w_btn_s) begin
            r_state   <= ST_RELEASED;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == c_deb_last) begin
            r_state    <= ST_PRESSED;
            r_deb_cnt  <= '0;
            r_press_ev <= 1'b1;
`ifdef FST_IN_AUTOREPEAT_EN
            r_rpt_cnt  <= '0;
`endif
          end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_one;
          end
        end
        ST_PRESSED: begin
          if (w_btn_s) begin
            r_state   <= ST_RELEASE_WAIT;
            r_deb_cnt <= c_deb_one;
`ifdef FST_IN_AUTOREPEAT_EN
            r_rpt_cnt <= '0;
          end else if (r_rpt_cnt == c_rpt_last) begin
            r_rpt_cnt  <= '0;
            r_press_ev <= 1'b1;
          end else begin
            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
`endif
          end
        end
        ST_RELEASE_WAIT: begin
          if (!w_btn_s) begin
            r_state   <= ST_PRESSED;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == c_deb_last) begin
            r_state   <= ST_RELEASED;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_one;
          end
        end
        default: begin
          r_state   <= ST_RELEASED;
          r_deb_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_in_dat;
  logic              r_valid;
  logic              r_full;
  logic              r_overflow;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [DATA_W-1:0] w_head_nxt;

  // A pop frees a slot, so a press arriving with a pop is accepted even when full
  assign w_pop    = bus.rd_req && r_valid;
  assign w_push   = r_press_ev && (!r_full || w_pop);
  assign w_drop   = r_press_ev && r_full && !w_pop;
  assign w_rd_nxt = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

  // Next occupancy and next head word, so in_dat can be registered
  always_comb begin
    w_cnt_nxt  = r_count;
    w_head_nxt = '0;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_count + c_cnt_one;
    end else if (w_pop && !w_push) begin
      w_cnt_nxt = r_count - c_cnt_one;
    end
    if (w_cnt_nxt != '0) begin
      // A single remaining entry that is being written now is not in memory yet
      if (w_push && (w_cnt_nxt == c_cnt_one)) begin
        w_head_nxt = r_sw_s;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  // Storage array: written at the tail on an accepted press
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_sw_s;
    end
  end

  // Pointers, occupancy, registered head and status flags
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_dat   <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_in_dat <= w_head_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      r_full   <= (w_cnt_nxt == c_depth);
      // A drop wins over a simultaneous clear
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.in_dat     = r_in_dat;
  assign bus.in_valid   = r_valid;
  assign bus.fifo_full  = r_full;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_fst_in_port.sv
// ============================================================================
// Module      : tb_fst_in_port
// Description : Directed self-checking bench for fst_in_port with
//               DEBOUNCE_CYC=4, DEPTH=4, REPEAT_CYC=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fst_in_port;

  logic clk_in;
  logic reset_n_in;
  int   checks;
  int   errors;

  fst_in_port_if #(.DATA_W(16), .DEPTH(4)) bus ();

  fst_in_port #(
    .DATA_W       (16),
    .DEPTH        (4),
    .DEBOUNCE_CYC (4),
    .REPEAT_CYC   (8)
  ) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one rising edge, then settle 1 time unit
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean press long enough to debounce, then clean release
  task automatic press(input logic [15:0] val);
    bus.sw_in    = val;
    bus.btn_n_in = 1'b0;
    repeat (10) tick();
    bus.btn_n_in = 1'b1;
    repeat (10) tick();
  endtask

  task automatic pop();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n_in   = 1'b0;
    bus.sw_in    = 16'h5555;
    bus.btn_n_in = 1'b0;
    bus.rd_req   = 1'b0;
    bus.clr_ovf  = 1'b0;

    // Reset held 3 cycles with the button already down
    repeat (3) tick();
    chk("rst_in_valid",   32'(bus.in_valid),   32'h0);
    chk("rst_in_dat",     32'(bus.in_dat),     32'h0);
    chk("rst_count",      32'(bus.fifo_count), 32'h0);
    chk("rst_full",       32'(bus.fifo_full),  32'h0);
    chk("rst_overflow",   32'(bus.overflow),   32'h0);

    // Press debounces after release: push lands on edge 7
    reset_n_in = 1'b1;
    repeat (6) tick();
    chk("rst_lat_edge6_valid", 32'(bus.in_valid), 32'h0);
    tick();
    chk("rst_lat_edge7_valid", 32'(bus.in_valid), 32'h1);
    chk("rst_lat_dat",         32'(bus.in_dat),   32'h5555);
    chk("rst_lat_count",       32'(bus.fifo_count), 32'h1);
    bus.btn_n_in = 1'b1;
    repeat (10) tick();
    pop();
    chk("rst_pop_valid", 32'(bus.in_valid), 32'h0);

    // Bounce: 2-cycle low/high runs never reach the 4-cycle threshold
    bus.sw_in = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      bus.btn_n_in = 1'b0;
      repeat (2) tick();
      bus.btn_n_in = 1'b1;
      repeat (2) tick();
    end
    chk("bounce_no_entry", 32'(bus.fifo_count), 32'h0);
    bus.btn_n_in = 1'b0;
    repeat (10) tick();
    bus.btn_n_in = 1'b1;
    repeat (10) tick();
    chk("bounce_count", 32'(bus.fifo_count), 32'h1);
    chk("bounce_dat",   32'(bus.in_dat),     32'h1234);
    pop();
    chk("bounce_empty", 32'(bus.fifo_count), 32'h0);

    // Ordering: press / read three times
    press(16'h0001);
    chk("ord_dat1", 32'(bus.in_dat), 32'h0001);
    pop();
    press(16'h0002);
    chk("ord_dat2", 32'(bus.in_dat), 32'h0002);
    pop();
    press(16'h0003);
    chk("ord_dat3", 32'(bus.in_dat), 32'h0003);
    pop();
    chk("ord_valid_end", 32'(bus.in_valid), 32'h0);
    chk("ord_dat_end",   32'(bus.in_dat),   32'h0);

    // Full / overflow: five presses into four slots
    for (int i = 0; i < 5; i++) press(16'h00A0 + 16'(i));
    chk("full_flag",  32'(bus.fifo_full),  32'h1);
    chk("full_count", 32'(bus.fifo_count), 32'h4);
    chk("full_ovf",   32'(bus.overflow),   32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("full_pop_dat", 32'(bus.in_dat), 32'h00A0 + 32'(i));
      pop();
    end
    chk("full_drained_valid", 32'(bus.in_valid), 32'h0);
    chk("full_ovf_sticky",    32'(bus.overflow), 32'h1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("full_ovf_clr", 32'(bus.overflow), 32'h0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) press(16'h00B0 + 16'(i));
    chk("sim_pre_full", 32'(bus.fifo_full), 32'h1);
    bus.sw_in    = 16'h00B4;
    bus.btn_n_in = 1'b0;
    repeat (6) tick();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("sim_count", 32'(bus.fifo_count), 32'h4);
    chk("sim_ovf",   32'(bus.overflow),   32'h0);
    chk("sim_head",  32'(bus.in_dat),     32'h00B1);
    bus.btn_n_in = 1'b1;
    repeat (10) tick();
    for (int i = 1; i < 5; i++) begin
      chk("sim_pop_dat", 32'(bus.in_dat), 32'h00B0 + 32'(i));
      pop();
    end
    pop();
    chk("empty_rd_count", 32'(bus.fifo_count), 32'h0);
    chk("empty_rd_valid", 32'(bus.in_valid),   32'h0);
    chk("empty_rd_dat",   32'(bus.in_dat),     32'h0);
    chk("empty_rd_ovf",   32'(bus.overflow),   32'h0);

    // Long hold: PRESSED reached at edge 6, button seen high again at edge 37
    bus.sw_in    = 16'h00C7;
    bus.btn_n_in = 1'b0;
    repeat (34) tick();
    bus.btn_n_in = 1'b1;
    repeat (12) tick();
`ifdef FST_IN_AUTOREPEAT_EN
    chk("hold_count", 32'(bus.fifo_count), 32'h4);
`else
    chk("hold_count", 32'(bus.fifo_count), 32'h1);
`endif
    chk("hold_dat", 32'(bus.in_dat), 32'h00C7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
